// File: rtl/uart_serial_pair.sv
// Full-duplex 8N1 UART: independent transmitter and receiver sharing clock, reset and baud timing.
// Handshake: a byte is taken on any rising edge with tx_din_vld=1 and busy=0 (requests while busy are dropped, not queued); rx_dout_vld is a one-cycle strobe with no ready, so the consumer must capture rx_dout on that cycle.
module uart_serial_pair #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int BIT_CYC  = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_din,
    input  logic       tx_din_vld,
    output logic       tx,
    output logic       busy,
    input  logic       rx,
    output logic [7:0] rx_dout,
    output logic       rx_dout_vld
);

    localparam int CNT_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYC / 2 - 1);

    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    tx_state_t        tx_state, tx_state_nxt;
    logic [CNT_W-1:0] tx_baud, tx_baud_nxt;
    logic [3:0]       tx_bit, tx_bit_nxt;
    logic [7:0]       tx_shreg, tx_shreg_nxt;
    logic             tx_nxt, busy_nxt;

    rx_state_t        rx_state, rx_state_nxt;
    logic [CNT_W-1:0] rx_baud, rx_baud_nxt;
    logic [2:0]       rx_bit, rx_bit_nxt;
    logic [7:0]       rx_shreg, rx_shreg_nxt;
    logic [7:0]       rx_dout_nxt;
    logic             rx_dout_vld_nxt;
    logic             rx_s1, rx_s2, rx_d;
    logic             rx_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_baud  <= '0;
            tx_bit   <= '0;
            tx_shreg <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            tx_state <= tx_state_nxt;
            tx_baud  <= tx_baud_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_shreg <= tx_shreg_nxt;
            tx       <= tx_nxt;
            busy     <= busy_nxt;
        end
    end

    // tx is registered, so each line level is set one cycle ahead on the baud wrap.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_baud_nxt  = tx_baud;
        tx_bit_nxt   = tx_bit;
        tx_shreg_nxt = tx_shreg;
        tx_nxt       = tx;
        busy_nxt     = busy;
        case (tx_state)
            TX_IDLE: begin
                if (tx_din_vld) begin
                    tx_state_nxt = TX_SEND;
                    tx_shreg_nxt = tx_din;
                    tx_baud_nxt  = '0;
                    tx_bit_nxt   = '0;
                    tx_nxt       = 1'b0;
                    busy_nxt     = 1'b1;
                end
            end
            TX_SEND: begin
                if (tx_baud == BAUD_LAST) begin
                    tx_baud_nxt = '0;
                    if (tx_bit == 4'd9) begin
                        tx_state_nxt = TX_IDLE;
                        tx_nxt       = 1'b1;
                        busy_nxt     = 1'b0;
                    end else begin
                        tx_bit_nxt = tx_bit + 4'd1;
                        if (tx_bit == 4'd8) begin
                            tx_nxt = 1'b1;
                        end else begin
                            tx_nxt       = tx_shreg[0];
                            tx_shreg_nxt = {1'b0, tx_shreg[7:1]};
                        end
                    end
                end else begin
                    tx_baud_nxt = tx_baud + 1'b1;
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1       <= 1'b1;
            rx_s2       <= 1'b1;
            rx_d        <= 1'b1;
            rx_state    <= RX_IDLE;
            rx_baud     <= '0;
            rx_bit      <= '0;
            rx_shreg    <= '0;
            rx_dout     <= 8'h00;
            rx_dout_vld <= 1'b0;
        end else begin
            rx_s1       <= rx;
            rx_s2       <= rx_s1;
            rx_d        <= rx_s2;
            rx_state    <= rx_state_nxt;
            rx_baud     <= rx_baud_nxt;
            rx_bit      <= rx_bit_nxt;
            rx_shreg    <= rx_shreg_nxt;
            rx_dout     <= rx_dout_nxt;
            rx_dout_vld <= rx_dout_vld_nxt;
        end
    end

    // A start needs a real high-to-low transition, so after a framing error the
    // line must return high before the receiver can arm again.
    assign rx_fall = rx_d & ~rx_s2;

    always_comb begin
        rx_state_nxt    = rx_state;
        rx_baud_nxt     = rx_baud;
        rx_bit_nxt      = rx_bit;
        rx_shreg_nxt    = rx_shreg;
        rx_dout_nxt     = rx_dout;
        rx_dout_vld_nxt = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_state_nxt = RX_START;
                    rx_baud_nxt  = '0;
                end
            end
            RX_START: begin
                if (rx_baud == HALF_LAST) begin
                    rx_baud_nxt = '0;
                    rx_bit_nxt  = '0;
                    rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
                end else begin
                    rx_baud_nxt = rx_baud + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_baud == BAUD_LAST) begin
                    rx_baud_nxt  = '0;
                    rx_shreg_nxt = {rx_s2, rx_shreg[7:1]};
                    rx_bit_nxt   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) begin
                        rx_state_nxt = RX_STOP;
                    end
                end else begin
                    rx_baud_nxt = rx_baud + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_baud == BAUD_LAST) begin
                    rx_baud_nxt  = '0;
                    rx_state_nxt = RX_IDLE;
                    if (rx_s2) begin
                        rx_dout_nxt     = rx_shreg;
                        rx_dout_vld_nxt = 1'b1;
                    end
                end else begin
                    rx_baud_nxt = rx_baud + 1'b1;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_serial_pair.sv
// Loopback bench for uart_serial_pair: random and directed bytes, hand-driven bad frames,
// line-waveform and busy-length checks, and a queue-based scoreboard on the receive strobe.
module tb_uart_serial_pair;

    localparam int BIT_CYC = 434;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_din;
    logic       tx_din_vld;
    logic       tx;
    logic       busy;
    logic       rx;
    logic [7:0] rx_dout;
    logic       rx_dout_vld;
    logic       loopback;
    logic       rx_drv;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_good;

    always #10 clk = ~clk;

    assign rx = loopback ? tx : rx_drv;

    uart_serial_pair #(
        .CLK_FREQ(50_000_000),
        .BAUD    (115200)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_din     (tx_din),
        .tx_din_vld (tx_din_vld),
        .tx         (tx),
        .busy       (busy),
        .rx         (rx),
        .rx_dout    (rx_dout),
        .rx_dout_vld(rx_dout_vld)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Line level of an 8N1 frame at bit slot idx: start 0, data LSB first, stop 1.
    function automatic logic frame_level(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return d[idx-1];
    endfunction

    // Monitor: every receive strobe must match the oldest byte still owed.
    always @(negedge clk) begin
        if (rx_dout_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_vld", {24'h0, rx_dout, 1'b0} | 32'(rx_dout_vld), 32'h0);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check($sformatf("rx_byte_%02h", e), 32'(rx_dout), 32'(e));
                last_good = e;
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input bit intrude, input bit push);
        int wave_err = 0;
        int busy_err = 0;
        @(negedge clk);
        tx_din     = d;
        tx_din_vld = 1'b1;
        if (push) exp_q.push_back(d);
        @(negedge clk);
        tx_din_vld = 1'b0;
        for (int w = 0; w < 4 && busy !== 1'b1; w++) @(negedge clk);
        check($sformatf("busy_rise_%02h", d), 32'(busy), 32'h1);
        if (busy !== 1'b1) return;
        for (int t = 0; t < 10 * BIT_CYC; t++) begin
            if (tx !== frame_level(d, t / BIT_CYC)) wave_err++;
            if (busy !== 1'b1) busy_err++;
            if (intrude && t == 3 * BIT_CYC) begin
                tx_din     = 8'h12;
                tx_din_vld = 1'b1;
            end
            if (intrude && t == 3 * BIT_CYC + 1) tx_din_vld = 1'b0;
            @(negedge clk);
        end
        check($sformatf("wave_%02h", d), 32'(wave_err), 32'h0);
        check($sformatf("busy_hold_%02h", d), 32'(busy_err), 32'h0);
        check($sformatf("busy_fall_%02h", d), 32'(busy), 32'h0);
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop);
        for (int i = 0; i < 10; i++) begin
            rx_drv = (i == 9) ? stop : frame_level(d, i);
            repeat (BIT_CYC) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        bad++;
        $display("FAIL watchdog: got timeout want finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        logic [7:0] dir[4];
        dir[0] = 8'hAA; dir[1] = 8'h55; dir[2] = 8'hEF; dir[3] = 8'hAE;
        loopback   = 1'b1;
        rx_drv     = 1'b1;
        rst        = 1'b1;
        tx_din     = 8'h00;
        tx_din_vld = 1'b0;
        last_good  = 8'h00;
        repeat (20) @(negedge clk);
        check("rst_tx", 32'(tx), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_rx_dout", 32'(rx_dout), 32'h0);
        check("rst_rx_vld", 32'(rx_dout_vld), 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        foreach (dir[i]) begin
            send_byte(dir[i], 1'b0, 1'b1);
            repeat (10) @(negedge clk);
        end

        // A request during a frame must be dropped, not queued.
        send_byte(8'h34, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        check("no_queue_busy", 32'(busy), 32'h0);
        check("no_queue_tx", 32'(tx), 32'h1);
        repeat (BIT_CYC) @(negedge clk);

        loopback = 1'b0;
        rx_drv   = 1'b0;
        repeat (BIT_CYC / 4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * BIT_CYC) @(negedge clk);
        check("glitch_hold", 32'(rx_dout), 32'(last_good));

        drive_frame(8'h3C, 1'b0);
        repeat (2 * BIT_CYC) @(negedge clk);
        check("framing_hold", 32'(rx_dout), 32'(last_good));
        loopback = 1'b1;
        repeat (10) @(negedge clk);
        send_byte(8'hC3, 1'b0, 1'b1);
        repeat (BIT_CYC) @(negedge clk);

        // Reset in the middle of a transmitted frame.
        tx_din     = 8'h77;
        tx_din_vld = 1'b1;
        @(negedge clk);
        tx_din_vld = 1'b0;
        repeat (4 * BIT_CYC) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tx", 32'(tx), 32'h1);
        check("midrst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        last_good = 8'h00;
        check("midrst_rx_dout", 32'(rx_dout), 32'h0);
        repeat (2 * BIT_CYC) @(negedge clk);
        send_byte(8'h5A, 1'b0, 1'b1);
        repeat (10) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            send_byte(8'($urandom_range(0, 255)), 1'b0, 1'b1);
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end

        repeat (2 * BIT_CYC) @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'h0);
        check("final_rx_dout", 32'(rx_dout), 32'(last_good));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
